// File: rtl/irrigation_sched_pkg.sv
// irrigation_sched_pkg: shared state encoding and defaults for the irrigation scheduler
package irrigation_sched_pkg;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} sched_state_t;
   localparam int DEF_DUR_W = 8;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set req bit at or after ptr
module rr_arbiter #(
   parameter int N = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          valid
);
   always_comb begin : search
      int j;
      gnt = '0;
      gnt_idx = '0;
      valid = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr) + k) % N;
         if (!valid && req[j]) begin
            valid = 1'b1;
            gnt[j] = 1'b1;
            gnt_idx = IW'(j);
         end
      end
   end
endmodule

// File: rtl/irrigation_scheduler.sv
// irrigation_scheduler: round-robin sharing of one three-phase sequencer across zones,
// with per-run timeout, zero-duration rejection and a guard gap between grants
module irrigation_scheduler
   import irrigation_sched_pkg::*;
#(
   parameter int N_ZONES = 4,
   parameter int DUR_W = DEF_DUR_W,
   parameter int TIMEOUT_CYCLES = 1023,
   parameter int GAP_CYCLES = 2,
   localparam int IW = $clog2(N_ZONES),
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1,
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     sched_enable,
   input  logic [N_ZONES-1:0]       zone_req,
   input  logic [N_ZONES*DUR_W-1:0] cfg_dur1,
   input  logic [N_ZONES*DUR_W-1:0] cfg_dur2,
   input  logic [N_ZONES*DUR_W-1:0] cfg_dur3,
   input  logic                     seq_done,
   output logic                     seq_enable,
   output logic [DUR_W-1:0]         seq_dur1,
   output logic [DUR_W-1:0]         seq_dur2,
   output logic [DUR_W-1:0]         seq_dur3,
   output logic [N_ZONES-1:0]       grant,
   output logic [IW-1:0]            cur_zone,
   output logic [N_ZONES-1:0]       pending,
   output logic [N_ZONES-1:0]       zone_ack,
   output logic [N_ZONES-1:0]       zone_fault,
   output logic                     busy
);
   sched_state_t       state_q, state_d;
   logic [N_ZONES-1:0] pending_q, pending_d, ack_q, ack_d, fault_q, fault_d;
   logic [IW-1:0]      ptr_q, ptr_d, cur_zone_q, cur_zone_d;
   logic [DUR_W-1:0]   dur1_q, dur1_d, dur2_q, dur2_d, dur3_q, dur3_d;
   logic [TW-1:0]      timer_q, timer_d;
   logic [GW-1:0]      gap_q, gap_d;
   logic [N_ZONES-1:0] arb_gnt, zone_oh;
   logic [IW-1:0]      arb_idx;
   logic               arb_valid;
   logic [DUR_W-1:0]   w_dur1, w_dur2, w_dur3;

   function automatic logic [IW-1:0] nxt(input logic [IW-1:0] z);
      return (z == IW'(N_ZONES - 1)) ? '0 : z + 1'b1;
   endfunction

   rr_arbiter #(.N(N_ZONES)) u_arb (
      .req(pending_q),
      .ptr(ptr_q),
      .gnt(arb_gnt),
      .gnt_idx(arb_idx),
      .valid(arb_valid)
   );

   assign w_dur1 = cfg_dur1[arb_idx*DUR_W +: DUR_W];
   assign w_dur2 = cfg_dur2[arb_idx*DUR_W +: DUR_W];
   assign w_dur3 = cfg_dur3[arb_idx*DUR_W +: DUR_W];
   assign zone_oh = N_ZONES'(1) << cur_zone_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         pending_q <= '0;
         ack_q <= '0;
         fault_q <= '0;
         ptr_q <= '0;
         cur_zone_q <= '0;
         dur1_q <= '0;
         dur2_q <= '0;
         dur3_q <= '0;
         timer_q <= '0;
         gap_q <= '0;
      end else begin
         state_q <= state_d;
         pending_q <= pending_d;
         ack_q <= ack_d;
         fault_q <= fault_d;
         ptr_q <= ptr_d;
         cur_zone_q <= cur_zone_d;
         dur1_q <= dur1_d;
         dur2_q <= dur2_d;
         dur3_q <= dur3_d;
         timer_q <= timer_d;
         gap_q <= gap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d = ptr_q;
      cur_zone_d = cur_zone_q;
      dur1_d = dur1_q;
      dur2_d = dur2_q;
      dur3_d = dur3_q;
      timer_d = timer_q;
      gap_d = gap_q;
      ack_d = '0;
      fault_d = '0;
      if (state_q == S_IDLE) begin
         if (sched_enable && arb_valid) begin
            // a zero phase would hang the sequencer, so reject it without granting
            if (w_dur1 == '0 || w_dur2 == '0 || w_dur3 == '0) begin
               fault_d = arb_gnt;
               ptr_d = nxt(arb_idx);
            end else begin
               state_d = S_RUN;
               cur_zone_d = arb_idx;
               dur1_d = w_dur1;
               dur2_d = w_dur2;
               dur3_d = w_dur3;
               timer_d = '0;
            end
         end
      end else if (state_q == S_RUN) begin
         timer_d = timer_q + 1'b1;
         if (seq_done || timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d = S_GAP;
            gap_d = '0;
            ptr_d = nxt(cur_zone_q);
            ack_d = seq_done ? zone_oh : '0;
            fault_d = seq_done ? '0 : zone_oh;
         end else if (!sched_enable) begin
            state_d = S_GAP;
            gap_d = '0;
         end
      end else begin
         gap_d = gap_q + 1'b1;
         state_d = (gap_q == GW'(GAP_CYCLES - 1)) ? S_IDLE : S_GAP;
      end
      pending_d = (pending_q & ~(ack_d | fault_d)) | zone_req;
   end

   always_comb begin
      seq_enable = (state_q == S_RUN);
      grant = seq_enable ? zone_oh : '0;
      busy = (state_q != S_IDLE);
   end

   assign seq_dur1 = dur1_q;
   assign seq_dur2 = dur2_q;
   assign seq_dur3 = dur3_q;
   assign cur_zone = cur_zone_q;
   assign pending = pending_q;
   assign zone_ack = ack_q;
   assign zone_fault = fault_q;
endmodule

// File: tb/tb_irrigation_scheduler.sv
// tb_irrigation_scheduler: directed vector table plus hand-written corner sequences
module tb_irrigation_scheduler;
   typedef struct {
      int         zone;
      int         d1;
      int         d2;
      int         d3;
      int         en_lat;
      int         pulse_lat;
      logic [3:0] ack;
      logic [3:0] fault;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset, sched_enable, seq_done, seq_enable, busy, model_on;
   logic [3:0]  zone_req, grant, pending, zone_ack, zone_fault;
   logic [31:0] cfg_dur1, cfg_dur2, cfg_dur3;
   logic [7:0]  seq_dur1, seq_dur2, seq_dur3;
   logic [1:0]  cur_zone;
   int          checks = 0;
   int          failures = 0;
   int          en_cnt = 0;
   vec_t        vec[6];

   irrigation_scheduler #(.N_ZONES(4), .DUR_W(8), .TIMEOUT_CYCLES(20), .GAP_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .sched_enable(sched_enable), .zone_req(zone_req),
      .cfg_dur1(cfg_dur1), .cfg_dur2(cfg_dur2), .cfg_dur3(cfg_dur3), .seq_done(seq_done),
      .seq_enable(seq_enable), .seq_dur1(seq_dur1), .seq_dur2(seq_dur2), .seq_dur3(seq_dur3),
      .grant(grant), .cur_zone(cur_zone), .pending(pending), .zone_ack(zone_ack),
      .zone_fault(zone_fault), .busy(busy)
   );

   always #5 clk = ~clk;

   // sequencer model: done after d1+d2+d3 phase cycles plus one start cycle
   always @(posedge clk) en_cnt <= seq_enable ? en_cnt + 1 : 0;
   assign seq_done = model_on && seq_enable &&
                     (en_cnt == int'(seq_dur1) + int'(seq_dur2) + int'(seq_dur3) + 1);

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   task automatic do_reset;
      reset = 1'b1;
      tick;
      tick;
      reset = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_seq_enable"}, int'(seq_enable), 0);
      chk({tag, "_grant"}, int'(grant), 0);
      chk({tag, "_pending"}, int'(pending), 0);
      chk({tag, "_ack"}, int'(zone_ack), 0);
      chk({tag, "_fault"}, int'(zone_fault), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_cur_zone"}, int'(cur_zone), 0);
      chk({tag, "_durs"}, int'({seq_dur1, seq_dur2, seq_dur3}), 0);
   endtask

   initial begin
      int en_at, pulse_at, n, low, flt;
      logic prev;
      logic [3:0] ackv, fltv;
      int order[4];
      int ack_cnt[4];
      int busy_hist[3];
      vec[0] = '{0, 3, 2, 4, 2, 13, 4'b0001, 4'b0000};
      vec[1] = '{2, 5, 0, 1, -1, 2, 4'b0000, 4'b0100};
      vec[2] = '{1, 1, 1, 1, 2, 7, 4'b0010, 4'b0000};
      vec[3] = '{3, 0, 7, 7, -1, 2, 4'b0000, 4'b1000};
      vec[4] = '{3, 2, 2, 2, 2, 10, 4'b1000, 4'b0000};
      vec[5] = '{1, 255, 1, 1, 2, 22, 4'b0000, 4'b0010};
      sched_enable = 1'b1;
      zone_req = '0;
      cfg_dur1 = '0;
      cfg_dur2 = '0;
      cfg_dur3 = '0;
      model_on = 1'b1;
      do_reset;
      chk_zero("reset");

      for (int v = 0; v < 6; v++) begin
         en_at = -1;
         pulse_at = -1;
         ackv = '0;
         fltv = '0;
         cfg_dur1[vec[v].zone*8 +: 8] = 8'(vec[v].d1);
         cfg_dur2[vec[v].zone*8 +: 8] = 8'(vec[v].d2);
         cfg_dur3[vec[v].zone*8 +: 8] = 8'(vec[v].d3);
         zone_req = 4'b0001 << vec[v].zone;
         for (int c = 1; c <= 40; c++) begin
            tick;
            zone_req = '0;
            if (seq_enable && en_at < 0) begin
               en_at = c;
               chk("vec_durs", int'({seq_dur1, seq_dur2, seq_dur3}),
                   (vec[v].d1 << 16) | (vec[v].d2 << 8) | vec[v].d3);
               chk("vec_grant", int'(grant), 1 << vec[v].zone);
            end
            if ((zone_ack | zone_fault) != '0 && pulse_at < 0) begin
               pulse_at = c;
               ackv = zone_ack;
               fltv = zone_fault;
            end
         end
         chk("vec_en_lat", en_at, vec[v].en_lat);
         chk("vec_pulse_lat", pulse_at, vec[v].pulse_lat);
         chk("vec_ack", int'(ackv), int'(vec[v].ack));
         chk("vec_fault", int'(fltv), int'(vec[v].fault));
         chk("vec_pending", int'(pending), 0);
         chk("vec_busy", int'(busy), 0);
      end

      do_reset;
      cfg_dur1 = {4{8'd1}};
      cfg_dur2 = {4{8'd1}};
      cfg_dur3 = {4{8'd1}};
      zone_req = 4'b1011;
      n = 0;
      low = 0;
      flt = 0;
      prev = 1'b0;
      for (int i = 0; i < 4; i++) begin
         order[i] = -1;
         ack_cnt[i] = 0;
      end
      for (int c = 0; c < 80; c++) begin
         tick;
         zone_req = '0;
         if (seq_enable && !prev) begin
            if (n > 0) chk("rr_gap_low", low, 3);
            if (n < 4) order[n] = int'(cur_zone);
            n++;
            if (n == 3) zone_req = 4'b0001;
         end
         low = seq_enable ? 0 : low + 1;
         prev = seq_enable;
         for (int i = 0; i < 4; i++) ack_cnt[i] += int'(zone_ack[i]);
         if (zone_fault != '0) flt++;
      end
      chk("rr_grants", n, 4);
      chk("rr_order0", order[0], 0);
      chk("rr_order1", order[1], 1);
      chk("rr_order2", order[2], 3);
      chk("rr_order3", order[3], 0);
      chk("rr_ack0", ack_cnt[0], 2);
      chk("rr_ack1", ack_cnt[1], 1);
      chk("rr_ack2", ack_cnt[2], 0);
      chk("rr_ack3", ack_cnt[3], 1);
      chk("rr_faults", flt, 0);
      chk("rr_pending", int'(pending), 0);

      cfg_dur1[7:0] = 8'd3;
      cfg_dur2[7:0] = 8'd2;
      cfg_dur3[7:0] = 8'd4;
      model_on = 1'b0;
      zone_req = 4'b0001;
      en_at = -1;
      pulse_at = -1;
      fltv = '0;
      flt = 0;
      for (int i = 0; i < 3; i++) busy_hist[i] = -1;
      for (int c = 1; c <= 60; c++) begin
         tick;
         zone_req = '0;
         if (seq_enable && en_at < 0) en_at = c;
         if (zone_fault != '0 && pulse_at < 0) begin
            pulse_at = c;
            fltv = zone_fault;
         end
         if (zone_ack != '0) flt++;
         if (pulse_at >= 0 && c - pulse_at < 3) busy_hist[c - pulse_at] = int'(busy);
      end
      model_on = 1'b1;
      chk("to_en_lat", en_at, 2);
      chk("to_run_len", pulse_at - en_at, 20);
      chk("to_fault", int'(fltv), 1);
      chk("to_no_ack", flt, 0);
      chk("to_gap0", busy_hist[0], 1);
      chk("to_gap1", busy_hist[1], 1);
      chk("to_idle", busy_hist[2], 0);

      cfg_dur1[15:8] = 8'd4;
      cfg_dur2[15:8] = 8'd4;
      cfg_dur3[15:8] = 8'd4;
      zone_req = 4'b0010;
      en_at = -1;
      for (int c = 1; c <= 10 && en_at < 0; c++) begin
         tick;
         zone_req = '0;
         if (seq_enable) en_at = c;
      end
      chk("abort_en_lat", en_at, 2);
      repeat (3) tick;
      sched_enable = 1'b0;
      tick;
      chk("abort_enable", int'(seq_enable), 0);
      chk("abort_grant", int'(grant), 0);
      chk("abort_pulse", int'(zone_ack | zone_fault), 0);
      chk("abort_pending", int'(pending), 2);
      repeat (4) tick;
      chk("abort_idle", int'(busy), 0);
      chk("abort_hold", int'(seq_enable), 0);
      chk("abort_pending2", int'(pending), 2);
      sched_enable = 1'b1;
      en_at = -1;
      pulse_at = -1;
      ackv = '0;
      for (int c = 1; c <= 40; c++) begin
         tick;
         zone_req = '0;
         if (seq_enable && en_at < 0) begin
            en_at = c;
            chk("rerun_durs", int'({seq_dur1, seq_dur2, seq_dur3}), 32'h040404);
         end
         if (zone_ack != '0 && pulse_at < 0) begin
            pulse_at = c;
            ackv = zone_ack;
            chk("requeue_pending", int'(pending[1]), 1);
         end
         if (seq_done && pulse_at < 0) zone_req = 4'b0010;
      end
      chk("rerun_en_lat", en_at, 1);
      chk("rerun_run_len", pulse_at - en_at, 14);
      chk("rerun_ack", int'(ackv), 2);
      chk("rerun_final_pending", int'(pending), 0);

      cfg_dur1[23:16] = 8'd8;
      cfg_dur2[23:16] = 8'd8;
      cfg_dur3[23:16] = 8'd8;
      zone_req = 4'b0100;
      en_at = -1;
      for (int c = 1; c <= 10 && en_at < 0; c++) begin
         tick;
         zone_req = '0;
         if (seq_enable) en_at = c;
      end
      chk("rst_en_lat", en_at, 2);
      tick;
      zone_req = 4'b1000;
      tick;
      zone_req = '0;
      chk("rst_pre_pending", int'(pending), 4'b1100);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk_zero("rst");
      flt = 0;
      for (int c = 0; c < 30; c++) begin
         tick;
         if (seq_enable || zone_ack != '0 || zone_fault != '0) flt++;
      end
      chk("rst_quiet", flt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
